// File: rtl/microseq.sv
// Microcode sequencer for the LED pattern engine: fetches from the microcode ROM,
// checks the echoed address and executes LED, WAIT, JMP, LDC/DJNZ and HALT words.
module microseq #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 9,
   parameter int LEDS  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   output logic             rom_en,
   output logic [DEPTH-1:0] rom_addr,
   input  logic [DEPTH-1:0] rom_daddr,
   input  logic [WIDTH-1:0] rom_dout,
   output logic [LEDS-1:0]  led,
   output logic             halted,
   output logic             err
);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WAIT, S_HALT} state_t;

   localparam logic [DEPTH-1:0] UPC_ONE = 1;

   state_t           state, state_n;
   logic [DEPTH-1:0] upc, upc_n;
   logic [LEDS-1:0]  led_n;
   logic [7:0]       lcnt, lcnt_n;
   logic [18:0]      wcnt, wcnt_n;
   logic             err_n;

   logic [3:0]       op;
   logic [DEPTH-1:0] tgt;
   logic [18:0]      imm;

   assign op  = rom_dout[31:28];
   assign tgt = rom_dout[19 +: DEPTH];
   assign imm = rom_dout[18:0];

   assign rom_en   = (state == S_FETCH);
   assign rom_addr = upc;
   assign halted   = (state == S_HALT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         upc   <= '0;
         led   <= '0;
         lcnt  <= '0;
         wcnt  <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_n;
         upc   <= upc_n;
         led   <= led_n;
         lcnt  <= lcnt_n;
         wcnt  <= wcnt_n;
         err   <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      upc_n   = upc;
      led_n   = led;
      lcnt_n  = lcnt;
      wcnt_n  = wcnt;
      err_n   = err;
      case (state)
         S_IDLE: begin
            if (run) state_n = S_FETCH;
         end
         S_FETCH: begin
            state_n = S_EXEC;
         end
         S_EXEC: begin
            state_n = run ? S_FETCH : S_IDLE;
            upc_n   = upc + UPC_ONE;
            // A stale/mismatched ROM word or an undefined opcode degrades to NOP.
            if ((rom_daddr != upc) || (op > 4'd6)) begin
               err_n = 1'b1;
            end else begin
               case (op)
                  4'd1: led_n = imm[LEDS-1:0];
                  4'd2: begin
                     if (imm != '0) begin
                        wcnt_n  = imm;
                        state_n = S_WAIT;
                     end
                  end
                  4'd3: upc_n = tgt;
                  4'd4: lcnt_n = imm[7:0];
                  4'd5: begin
                     if (lcnt != 8'd0) begin
                        lcnt_n = lcnt - 8'd1;
                        if (lcnt != 8'd1) upc_n = tgt;
                     end
                  end
                  4'd6: begin
                     upc_n   = upc;
                     state_n = S_HALT;
                  end
                  default: ;
               endcase
            end
         end
         S_WAIT: begin
            wcnt_n = wcnt - 19'd1;
            if (wcnt == 19'd1) state_n = run ? S_FETCH : S_IDLE;
         end
         S_HALT: ;
         default: state_n = S_IDLE;
      endcase
   end

endmodule
